// File: rtl/stdout_uart.sv
// stdout_uart: word FIFO for the system stdout stream, drained as ASCII hex
// lines ("XXXX\n") over an 8N1 UART. Draining is gated by stdout_flush_i
// unless the FIFO is full, so program output is batched.
module stdout_uart #(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       stdout_val_i,
    input  logic [15:0]                stdout_data_i,
    output logic                       stdout_rdy_o,
    input  logic                       stdout_flush_i,
    output logic                       uart_tx_o,
    output logic                       tx_busy_o,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level_o
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    state_t        r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [2:0]    r_char;
    logic [15:0]   r_word;
    logic          r_tx;
    logic          r_busy;

    logic          w_push;
    logic          w_pop;
    logic          w_baud_end;
    logic [7:0]    w_char;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction

    assign stdout_rdy_o = (r_level != LW'(DEPTH));
    assign w_push       = stdout_val_i && stdout_rdy_o;
    // A full FIFO drains on its own so the producer cannot stall forever.
    assign w_pop        = (r_state == S_IDLE) && (r_level != '0) &&
                          (stdout_flush_i || !stdout_rdy_o);
    assign w_baud_end   = (r_baud == BW'(CLKS_PER_BIT - 1));

    assign uart_tx_o    = r_tx;
    assign tx_busy_o    = r_busy;
    assign fifo_level_o = r_level;

    // Select the character being sent: four hex nibbles, MSB first, then LF.
    always_comb begin
        w_char = 8'h0A;
        case (r_char)
            3'd0:    w_char = hex_ascii(r_word[15:12]);
            3'd1:    w_char = hex_ascii(r_word[11:8]);
            3'd2:    w_char = hex_ascii(r_word[7:4]);
            3'd3:    w_char = hex_ascii(r_word[3:0]);
            default: w_char = 8'h0A;
        endcase
    end

    // FIFO storage and the popped-word shift source (data only, never reset).
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= stdout_data_i;
        if (w_pop)  r_word          <= r_mem[r_rd_ptr];
    end

    // FIFO pointers wrap modulo DEPTH; level tracks push minus pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            if (w_push && !w_pop)
                r_level <= r_level + LW'(1);
            else if (w_pop && !w_push)
                r_level <= r_level - LW'(1);
        end
    end

    // Serializer FSM: start, 8 data bits LSB first, stop; five characters per word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_char  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_START;
                        r_baud  <= '0;
                        r_char  <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_state <= S_DATA;
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= w_char[0];
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= w_char[r_bit + 3'd1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_char == 3'd4) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_START;
                            r_char  <= r_char + 3'd1;
                            r_tx    <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/stdout_uart.md
# stdout_uart

Consumer end of the system stdout stream. Accepts 16-bit words on the `stdout_val`/`stdout_rdy` handshake and buffers them in a word FIFO. Drains the FIFO as ASCII text over an 8N1 UART line: four uppercase hex digits followed by a line feed per word. Drain is gated by `stdout_flush` so that a running program's output is batched. The block sits beside `system` at the board top, wired to `stdout_val_o`, `stdout_data_o`, `stdout_rdy_i` and `stdout_flush_o`.

## Interface
Parameters:
- `DEPTH`, 16 — FIFO capacity in words; must be ≥2.
- `CLKS_PER_BIT`, 868 — clock cycles per UART bit; must be ≥2. The default gives 115200 baud at 100 MHz.

Ports:
- `clk_i` in 1 — the single clock; everything is posedge.
- `rst_ni` in 1 — asynchronous, active-low reset.
- `stdout_val_i` in 1 — a word is offered.
- `stdout_data_i` in 16 — the offered word.
- `stdout_rdy_o` out 1 — the FIFO can accept a word.
- `stdout_flush_i` in 1 — permission to drain the FIFO.
- `uart_tx_o` out 1 — serial line; idles high.
- `tx_busy_o` out 1 — a word is being serialized.
- `fifo_level_o` out $clog2(DEPTH+1) — number of words currently queued.

## Operation
- **Push.** A word is accepted on any cycle where `stdout_val_i && stdout_rdy_o`.
  - `stdout_rdy_o = (fifo_level_o != DEPTH)`. It is purely combinational from the registered count.
  - Data must be held by the producer until accepted.
- **Pop.** A pop happens only in state IDLE, when the FIFO is non-empty and (`stdout_flush_i` or FIFO full).
  - The popped word is latched into a 16-bit shift source.
  - Push and pop in the same cycle: the level is unchanged and both take effect.
  - When full, no push can coincide with the pop because `rdy` is low.
- **Word framing.** Each word produces exactly 5 characters:
  - hex nibbles [15:12], [11:8], [7:4], [3:0];
  - 0–9 map to 0x30–0x39; A–F map to 0x41–0x46 (uppercase only);
  - then 0x0A.
- **Character framing.**
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit lasts exactly `CLKS_PER_BIT` cycles.
- **State machine.**
  - IDLE → START on pop.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits.
  - STOP → START with the next character, if the character index is below 4.
  - STOP → IDLE after character 4.
- **Counters.** A baud counter, a bit index (0–7) and a character index (0–4).
- **Flush gating.** Once a word has been popped, all 5 characters are sent even if `stdout_flush_i` falls mid-word. The flag is sampled only in IDLE.
- **Outputs.** `tx_busy_o` is high in every state except IDLE. `uart_tx_o` is registered.
- **Reset.** Reset at any time, including mid-character, takes effect asynchronously:
  - FIFO empties;
  - FSM goes to IDLE;
  - `uart_tx_o=1`, `tx_busy_o=0`, `fifo_level_o=0`, `stdout_rdy_o=1`.
  - A truncated character is abandoned; no resend.

## Timing
- **Pop to first edge.** A pop decided in cycle N drives `uart_tx_o` low from cycle N+1.
- **Character and word length.** A character occupies 10·`CLKS_PER_BIT` cycles. A word occupies 50·`CLKS_PER_BIT` cycles.
- **No gap within a word.** Characters within a word are back-to-back: the stop bit is followed immediately by the next start bit.
- **Gap between words.** The line spends exactly 1 IDLE cycle (high) between the end of one word's final stop bit and the next pop. The next start bit therefore begins 2 cycles after the last stop cycle.
- **Level update.** `fifo_level_o` updates on the clock edge after a push or pop.
- **Ready after a pop.** When the FIFO was full, `stdout_rdy_o` rises the cycle after the pop.
- **Wrap-around.** FIFO read and write pointers wrap modulo `DEPTH`; `DEPTH` need not be a power of 2.

## Test plan
Benches use `CLKS_PER_BIT=4` and `DEPTH=4`.
1. **Single word.** Reset, flush=1, push 0x1A2F. The line must show 0x31, 0x41, 0x32, 0x46, 0x0A, each start bit 4 cycles low, 200 cycles total. `tx_busy_o` falls afterwards. Level goes 1→0 on the pop.
2. **Batching.** With flush=0, push 3 words. No line activity and level=3. Raising flush starts the drain the next cycle. Output words appear in push order, separated by a 1-cycle idle gap.
3. **Full FIFO.** With flush=0, push 4 words: `rdy` drops at level=4 and an auto-drain starts. A 5th word held on `val` is accepted the cycle after `rdy` returns. All 5 words are eventually sent in order.
4. **Flush drop mid-word.** Drop flush during the 2nd character of 0xFFFF. All of "FFFF\n" completes and the next queued word is not popped.
5. **Simultaneous push/pop.** Time a push to land in the pop cycle at level=2. Level stays 2 and the data order is preserved across the pointer wrap.
6. **Reset mid-character.** Assert `rst_ni` low during a DATA bit. `uart_tx_o=1`, `tx_busy_o=0` and level=0 immediately, without waiting for a clock edge. After release, the line stays idle until a new push.
